mem_arbiter: RTL

- Sole owner of the byte-wide RAM bus (mem_din/mem_dout/mem_a/mem_wr).
- Shares the bus between two requesters, each with its own port:
  - the instruction-fetch port, which only does 4-byte reads;
  - the data port, which does 1/2/4-byte loads and stores.
- Sequences each granted request as a pipelined burst of single-byte RAM accesses.
- Returns little-endian assembled words with a one-cycle done pulse.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM bus arbiter.
//   - SZ_*    : data-port access size encodings
//   - state_t : sequencer states
//   - req_id_t: requester identifiers
//   - ZeroWord: cleared 32-bit word
//   - size_to_len: access size code -> number of bytes (1, 2 or 4)
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Size code 11 is treated as a word access.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_len = 3'd1;
            SZ_HALF: size_to_len = 3'd2;
            default: size_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of a byte-wide RAM bus, shared between an
// instruction-fetch port (4-byte reads) and a data port (1/2/4-byte loads
// and stores). Each granted request runs as a pipelined burst of single-byte
// RAM accesses; read bytes are assembled little-endian.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; 0 freezes the block
//   mem_din         RAM read data (valid the cycle after its address)
//   mem_dout, mem_a, mem_wr   RAM write data, byte address, write strobe
//   if_req, if_addr           fetch request / address
//   if_rdata, if_done         fetched word / one-cycle completion pulse
//   dm_req, dm_we, dm_size, dm_addr, dm_wdata   data request
//   dm_rdata, dm_done         load data (zero-extended) / completion pulse
//   busy            high whenever the sequencer is not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit FAIR   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic              busy
);

    state_t              state_reg;
    req_id_t             owner_reg;
    req_id_t             last_grant_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   mem_a_reg;
    logic [7:0]          mem_dout_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         buf_reg;
    logic [31:0]         if_rdata_reg;
    logic [31:0]         dm_rdata_reg;
    logic [2:0]          len_reg;
    logic [2:0]          nxt_idx_reg;   // index of the next address to present
    logic [2:0]          cap_idx_reg;   // index of the next byte to capture
    logic                pres_reg;      // mem_a currently shows a wanted address
    logic                cap_reg;       // mem_din this cycle carries byte cap_idx
    logic                replay_reg;    // a capture was lost to a stall
    logic                wr_reg;
    logic                if_done_reg;
    logic                dm_done_reg;

    // Request selection for the IDLE state.
    logic                grant_dm_next;
    logic [ADDR_W-1:0]   acc_addr_next;
    logic [31:0]         acc_wdata_next;
    logic [2:0]          acc_len_next;
    logic                acc_we_next;
    logic [31:0]         merged_next;

    always_comb begin
        grant_dm_next = dm_req;
        if (dm_req && if_req) begin
            if (FAIR) begin
                grant_dm_next = (last_grant_reg == REQ_IF);
            end else begin
                grant_dm_next = 1'b1;
            end
        end
        if (grant_dm_next) begin
            acc_addr_next  = dm_addr;
            acc_wdata_next = dm_wdata;
            acc_len_next   = size_to_len(dm_size);
            acc_we_next    = dm_we;
        end else begin
            acc_addr_next  = if_addr;
            acc_wdata_next = ZeroWord;
            acc_len_next   = 3'd4;
            acc_we_next    = 1'b0;
        end
    end

    // Bytes land in distinct, still-zero lanes, so OR-ing assembles the word.
    assign merged_next = buf_reg | ({24'h0, mem_din} << {cap_idx_reg[1:0], 3'b000});

    function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    lane = w[7:0];
            2'd1:    lane = w[15:8];
            2'd2:    lane = w[23:16];
            default: lane = w[31:24];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= REQ_IF;
            last_grant_reg <= REQ_IF;
            base_reg       <= '0;
            mem_a_reg      <= '0;
            mem_dout_reg   <= 8'h00;
            wdata_reg      <= ZeroWord;
            buf_reg        <= ZeroWord;
            if_rdata_reg   <= ZeroWord;
            dm_rdata_reg   <= ZeroWord;
            len_reg        <= 3'd0;
            nxt_idx_reg    <= 3'd0;
            cap_idx_reg    <= 3'd0;
            pres_reg       <= 1'b0;
            cap_reg        <= 1'b0;
            replay_reg     <= 1'b0;
            wr_reg         <= 1'b0;
            if_done_reg    <= 1'b0;
            dm_done_reg    <= 1'b0;
        end else if (rdy) begin
            case (state_reg)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        owner_reg      <= grant_dm_next ? REQ_DM : REQ_IF;
                        last_grant_reg <= grant_dm_next ? REQ_DM : REQ_IF;
                        base_reg       <= acc_addr_next;
                        wdata_reg      <= acc_wdata_next;
                        len_reg        <= acc_len_next;
                        mem_a_reg      <= acc_addr_next;
                        nxt_idx_reg    <= 3'd1;
                        cap_idx_reg    <= 3'd0;
                        cap_reg        <= 1'b0;
                        replay_reg     <= 1'b0;
                        buf_reg        <= ZeroWord;
                        if (acc_we_next) begin
                            state_reg    <= ST_WR;
                            wr_reg       <= 1'b1;
                            mem_dout_reg <= acc_wdata_next[7:0];
                            pres_reg     <= 1'b0;
                        end else begin
                            state_reg    <= ST_RD;
                            pres_reg     <= 1'b1;
                        end
                    end
                end

                ST_RD: begin
                    if (replay_reg) begin
                        // This cycle re-presented addr+cap_idx (see mem_a mux);
                        // its data arrives next cycle, then the pipeline resumes.
                        replay_reg  <= 1'b0;
                        cap_reg     <= 1'b1;
                        mem_a_reg   <= base_reg + ADDR_W'(cap_idx_reg + 3'd1);
                        nxt_idx_reg <= cap_idx_reg + 3'd2;
                        pres_reg    <= ((cap_idx_reg + 3'd1) < len_reg);
                    end else begin
                        if (cap_reg) begin
                            buf_reg     <= merged_next;
                            cap_idx_reg <= cap_idx_reg + 3'd1;
                        end
                        cap_reg <= pres_reg;
                        if (pres_reg) begin
                            if (nxt_idx_reg < len_reg) begin
                                mem_a_reg   <= base_reg + ADDR_W'(nxt_idx_reg);
                                nxt_idx_reg <= nxt_idx_reg + 3'd1;
                            end else begin
                                pres_reg <= 1'b0;
                            end
                        end
                        if (cap_reg && (cap_idx_reg == len_reg - 3'd1)) begin
                            state_reg <= ST_FIN;
                            cap_reg   <= 1'b0;
                            if (owner_reg == REQ_IF) begin
                                if_rdata_reg <= merged_next;
                                if_done_reg  <= 1'b1;
                            end else begin
                                dm_rdata_reg <= merged_next;
                                dm_done_reg  <= 1'b1;
                            end
                        end
                    end
                end

                ST_WR: begin
                    if (nxt_idx_reg < len_reg) begin
                        mem_a_reg    <= base_reg + ADDR_W'(nxt_idx_reg);
                        mem_dout_reg <= lane(wdata_reg, nxt_idx_reg[1:0]);
                        nxt_idx_reg  <= nxt_idx_reg + 3'd1;
                    end else begin
                        wr_reg    <= 1'b0;
                        state_reg <= ST_FIN;
                        if (owner_reg == REQ_IF) begin
                            if_done_reg <= 1'b1;
                        end else begin
                            dm_done_reg <= 1'b1;
                        end
                    end
                end

                ST_FIN: begin
                    state_reg   <= ST_IDLE;
                    if_done_reg <= 1'b0;
                    dm_done_reg <= 1'b0;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end else begin
            // Stalled: everything visible is frozen. If the byte in flight was
            // due for capture this cycle, mem_din will be overwritten by the
            // next address's data, so remember to re-present it on resume.
            if (state_reg == ST_RD && cap_reg) begin
                replay_reg <= 1'b1;
            end
        end
    end

    // The replay address is shown only in the first rdy=1 cycle so that the
    // bus stays frozen while stalled.
    assign mem_a    = (state_reg == ST_RD && replay_reg && rdy)
                      ? base_reg + ADDR_W'(cap_idx_reg) : mem_a_reg;
    assign mem_wr   = wr_reg & rdy;
    assign mem_dout = mem_dout_reg;
    assign if_rdata = if_rdata_reg;
    assign dm_rdata = dm_rdata_reg;
    assign if_done  = if_done_reg;
    assign dm_done  = dm_done_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule
